// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants and types for the PS/2 key tracker: prefix/control byte codes,
// FSM encoding and the {ext,code} key identity used by the held-key table.
package ps2_key_tracker_pkg;

    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    localparam logic [7:0] PS2_CTL_ACK    = 8'hFA;
    localparam logic [7:0] PS2_CTL_BAT    = 8'hAA;
    localparam logic [7:0] PS2_CTL_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_CTL_RESEND = 8'hFE;
    localparam logic [7:0] PS2_CTL_ERR0   = 8'h00;
    localparam logic [7:0] PS2_CTL_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

    function automatic logic is_ctl(input logic [7:0] b);
        return (b == PS2_CTL_ACK)  || (b == PS2_CTL_BAT)    || (b == PS2_CTL_ECHO) ||
               (b == PS2_CTL_RESEND) || (b == PS2_CTL_ERR0) || (b == PS2_CTL_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte handshake between the PS/2 controller FIFO (master) and the tracker (slave).
interface ps2_key_tracker_if;
    logic       ready;
    logic [7:0] data;
    logic       nextdata_n;

    modport master (output ready, output data, input  nextdata_n);
    modport slave  (input  ready, input  data, output nextdata_n);
endinterface

// File: rtl/ps2_key_table.sv
// DEPTH-entry CAM of held keys: parallel match, lowest-free insert, remove by match.
// Lookups are combinational; insert/remove take effect on the next clock.
module ps2_key_table
    import ps2_key_tracker_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  key_id_t                      lookup,
    input  logic                         ins,
    input  logic                         rem,
    output logic                         hit,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   held
);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HELD_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid;
    key_id_t          ent [DEPTH];
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        hit      = 1'b0;
        full     = 1'b1;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (valid[i] && ent[i] == lookup) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                full     = 1'b0;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            held  <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (ins && !hit && !full) begin
            valid[free_idx] <= 1'b1;
            ent[free_idx]   <= lookup;
            held            <= held + HELD_W'(1);
        end else if (rem && hit) begin
            valid[hit_idx] <= 1'b0;
            held           <= held - HELD_W'(1);
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops scan-code bytes from the controller, folds E0/F0 prefixes into make/break events
// and tracks held keys. One byte per 3 cycles (IDLE->POP->EXEC); results appear the cycle after EXEC.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    ps2_key_tracker_if.slave            bus,
    output logic [7:0]                  key,
    output logic                        key_ext,
    output logic [CNT_W-1:0]            cnt,
    output logic [$clog2(DEPTH+1)-1:0]  held,
    output logic                        ev_valid,
    output logic [7:0]                  ev_code,
    output logic                        ev_ext,
    output logic                        ev_break,
    output logic                        table_ovf
);
    state_t     state;
    logic [7:0] byte_r;
    logic       ext_pend;
    logic       brk_pend;
    logic [2:0] skip_cnt;
    logic       is_event;
    logic       hit;
    logic       full;

    assign is_event = (state == ST_EXEC) && (skip_cnt == 3'd0) &&
                      (byte_r != PS2_PFX_PAUSE) && (byte_r != PS2_PFX_EXT) &&
                      (byte_r != PS2_PFX_BRK) && !is_ctl(byte_r);

    ps2_key_table #(.DEPTH(DEPTH)) u_table (
        .clk    (clk),
        .reset  (reset),
        .lookup ({ext_pend, byte_r}),
        .ins    (is_event && !brk_pend),
        .rem    (is_event && brk_pend),
        .hit    (hit),
        .full   (full),
        .held   (held)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            bus.nextdata_n <= 1'b1;
            byte_r         <= '0;
            ext_pend       <= 1'b0;
            brk_pend       <= 1'b0;
            skip_cnt       <= '0;
            key            <= '0;
            key_ext        <= 1'b0;
            cnt            <= '0;
            ev_valid       <= 1'b0;
            ev_code        <= '0;
            ev_ext         <= 1'b0;
            ev_break       <= 1'b0;
            table_ovf      <= 1'b0;
        end else begin
            ev_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ready) begin
                        byte_r         <= bus.data;
                        bus.nextdata_n <= 1'b0;
                        state          <= ST_POP;
                    end
                end
                ST_POP: begin
                    bus.nextdata_n <= 1'b1;
                    state          <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    if (skip_cnt != 3'd0) begin
                        skip_cnt <= skip_cnt - 3'd1;
                    end else if (byte_r == PS2_PFX_PAUSE) begin
                        skip_cnt <= PS2_PAUSE_SKIP;
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end else if (byte_r == PS2_PFX_EXT) begin
                        ext_pend <= 1'b1;
                    end else if (byte_r == PS2_PFX_BRK) begin
                        brk_pend <= 1'b1;
                    end else if (is_ctl(byte_r)) begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end else begin
                        ev_valid <= 1'b1;
                        ev_code  <= byte_r;
                        ev_ext   <= ext_pend;
                        ev_break <= brk_pend;
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        if (!brk_pend) begin
                            // A repeat only refreshes key; a full table drops the make.
                            if (hit || !full) begin
                                key     <= byte_r;
                                key_ext <= ext_pend;
                                if (!hit) cnt <= cnt + CNT_W'(1);
                            end else begin
                                table_ovf <= 1'b1;
                            end
                        end else if (hit && key == byte_r && key_ext == ext_pend) begin
                            key     <= 8'h00;
                            key_ext <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
